// File: rtl/polyphase_interp_fir_pkg.sv
// Shared types and helpers for the polyphase interpolating FIR.
//   state_e          : burst FSM states (IDLE waits for a sample, EMIT streams phases)
//   acc_width()      : full-precision accumulator width for a given geometry
//   round_shift_sat(): round-half-up, arithmetic shift, clamp to the output width
package interp_fir_pkg;

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_COEFF_WIDTH = 16;
   localparam int DEF_NUM_TAPS    = 48;
   localparam int DEF_INTERP      = 4;
   localparam int DEF_OUT_SHIFT   = 15;

   // Sum of TPP products of DW x CW signed values never overflows this width.
   function automatic int acc_width(input int dw, input int cw, input int taps, input int l);
      return dw + cw + $clog2(taps / l);
   endfunction

   // Works on a 64-bit view so one helper serves any accumulator width up to 63 bits.
   function automatic logic signed [63:0] round_shift_sat(input logic signed [63:0] acc,
                                                          input int shift, input int width,
                                                          output logic sat);
      logic signed [63:0] r, hi, lo;
      hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (width - 1));
      r   = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
      sat = 1'b0;
      if (r > hi) begin
         r   = hi;
         sat = 1'b1;
      end else if (r < lo) begin
         r   = lo;
         sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/polyphase_interp_fir_if.sv
// Sample/coefficient bus of the polyphase interpolating FIR.
//   in_*     : input sample valid/ready handshake
//   out_*    : output sample valid/ready handshake plus phase index
//   coef_*   : run-time coefficient write port
//   flush    : clears delay line and sat_flag (honoured only while idle)
//   sat_flag : sticky saturation indicator
// master = sample source / controller side, slave = the filter.
interface polyphase_interp_fir_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int NUM_TAPS    = 48,
   parameter int INTERP      = 4
);
   localparam int PH_W = $clog2(INTERP);
   localparam int AW   = $clog2(NUM_TAPS);

   logic                          in_valid;
   logic                          in_ready;
   logic signed [DATA_WIDTH-1:0]  in_data;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [DATA_WIDTH-1:0]  out_data;
   logic [PH_W-1:0]               out_phase;
   logic                          coef_we;
   logic [AW-1:0]                 coef_addr;
   logic signed [COEFF_WIDTH-1:0] coef_data;
   logic                          flush;
   logic                          sat_flag;

   modport master (
      output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, flush,
      input  in_ready, out_valid, out_data, out_phase, sat_flag
   );

   modport slave (
      input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, flush,
      output in_ready, out_valid, out_data, out_phase, sat_flag
   );
endinterface

// File: rtl/polyphase_interp_fir_dot.sv
// Combinational polyphase dot product.
//   x     : delay line, x[0] newest
//   h     : full prototype coefficient bank
//   phase : polyphase branch p, selecting taps h[k*INTERP+p]
//   acc   : full-precision signed sum, ACC_W bits
module polyphase_dot
   import interp_fir_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
   parameter int NUM_TAPS    = DEF_NUM_TAPS,
   parameter int INTERP      = DEF_INTERP,
   localparam int TPP   = NUM_TAPS / INTERP,
   localparam int PH_W  = $clog2(INTERP),
   localparam int ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS, INTERP)
) (
   input  logic [TPP-1:0][DATA_WIDTH-1:0]       x,
   input  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] h,
   input  logic [PH_W-1:0]                      phase,
   output logic signed [ACC_W-1:0]              acc
);
   logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;
   int                                       idx;

   always_comb begin
      acc  = '0;
      prod = '0;
      idx  = 0;
      for (int k = 0; k < TPP; k++) begin
         idx  = k * INTERP + int'(phase);
         prod = $signed(x[k]) * $signed(h[idx]);
         acc  = acc + ACC_W'(prod);
      end
   end
endmodule

// File: rtl/polyphase_interp_fir.sv
// Polyphase interpolating FIR: each accepted sample produces INTERP outputs,
// one per phase, with round/shift/saturate on the full-precision sum.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sample handshakes, coefficient write port, flush, sat_flag
// The output register is loaded from the *next* delay line / phase so that a
// sample accepted at edge t shows phase 0 at t+1, and the last phase can
// hand over to a new sample without a bubble.
module polyphase_interp_fir
   import interp_fir_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
   parameter int NUM_TAPS    = DEF_NUM_TAPS,
   parameter int INTERP      = DEF_INTERP,
   parameter int OUT_SHIFT   = DEF_OUT_SHIFT
) (
   input logic                   clk,
   input logic                   rst,
   polyphase_interp_fir_if.slave bus
);
   localparam int TPP   = NUM_TAPS / INTERP;
   localparam int PH_W  = $clog2(INTERP);
   localparam int ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS, INTERP);

   state_e                               state_q, state_d;
   logic [PH_W-1:0]                      phase_q, phase_d;
   logic [TPP-1:0][DATA_WIDTH-1:0]       x_q, x_d, x_sh;
   logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] h_q, h_d;
   logic [DATA_WIDTH-1:0]                out_q, out_d;
   logic                                 sat_q, sat_d;
   logic signed [ACC_W-1:0]              acc;
   logic signed [63:0]                   res;
   logic                                 res_sat;
   logic                                 load;
   logic                                 is_last;
   logic                                 unused_res_hi;

   assign is_last      = (phase_q == PH_W'(INTERP - 1));
   assign bus.in_ready = (state_q == IDLE) ? !bus.flush : (is_last && bus.out_ready);
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_data  = out_q;
   assign bus.out_phase = phase_q;
   assign bus.sat_flag  = sat_q;
   // Clamped result always fits DATA_WIDTH; upper bits are sign copies.
   assign unused_res_hi = ^res[63:DATA_WIDTH];

   polyphase_dot #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEFF_WIDTH(COEFF_WIDTH),
      .NUM_TAPS   (NUM_TAPS),
      .INTERP     (INTERP)
   ) u_dot (
      .x    (x_d),
      .h    (h_q),
      .phase(phase_d),
      .acc  (acc)
   );

   always_comb begin
      x_sh[0] = bus.in_data;
      for (int k = 1; k < TPP; k++) x_sh[k] = x_q[k-1];
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      x_d     = x_q;
      h_d     = h_q;
      out_d   = out_q;
      sat_d   = sat_q;
      load    = 1'b0;
      res_sat = 1'b0;
      res     = '0;
      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               x_d   = '0;
               sat_d = 1'b0;
            end else if (bus.in_valid) begin
               x_d     = x_sh;
               phase_d = '0;
               state_d = EMIT;
               load    = 1'b1;
            end else if (bus.coef_we && (32'(bus.coef_addr) < NUM_TAPS)) begin
               h_d[bus.coef_addr] = bus.coef_data;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               if (!is_last) begin
                  phase_d = phase_q + PH_W'(1);
                  load    = 1'b1;
               end else if (bus.in_valid) begin
                  x_d     = x_sh;
                  phase_d = '0;
                  load    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      res = round_shift_sat(64'(acc), OUT_SHIFT, DATA_WIDTH, res_sat);
      if (load) begin
         out_d = res[DATA_WIDTH-1:0];
         if (res_sat) sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         x_q     <= '0;
         h_q     <= '0;
         out_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         x_q     <= x_d;
         h_q     <= h_d;
         out_q   <= out_d;
         sat_q   <= sat_d;
      end
   end
endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Self-checking bench for polyphase_interp_fir (8 taps, L=4, Q15 output shift).
module tb_polyphase_interp_fir;
   localparam int DW = 16, CW = 16, NT = 8, L = 4, OS = 15, TPP = NT / L;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   polyphase_interp_fir_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .INTERP(L)) bus ();

   polyphase_interp_fir #(
      .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .INTERP(L), .OUT_SHIFT(OS)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model: coefficient bank, delay line, sticky saturation.
   longint h_m[NT];
   longint x_m[TPP];
   bit     sat_m;

   typedef struct {
      bit     fl;    // flush before the burst
      bit     ld;    // load every coefficient with coef
      longint coef;
      longint smp;
      longint e;     // expected output, same on every phase
      bit     sat;   // expected sat_flag after the burst
   } vec_t;
   vec_t tab[10];

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint model_out(input int p, output bit s);
      longint acc, r, hi, lo;
      acc = 0;
      for (int k = 0; k < TPP; k++) acc += h_m[k*L+p] * x_m[k];
      r  = (acc + (longint'(1) << (OS - 1))) >>> OS;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -(longint'(1) << (DW - 1));
      s  = 0;
      if (r > hi) begin r = hi; s = 1; end
      else if (r < lo) begin r = lo; s = 1; end
      return r;
   endfunction

   task automatic model_push(input longint s);
      for (int k = TPP - 1; k > 0; k--) x_m[k] = x_m[k-1];
      x_m[0] = s;
   endtask

   function automatic longint rnd16();
      return longint'($signed(16'($urandom)));
   endfunction

   // All drive tasks start and end at #1 after a rising edge.
   task automatic write_coef(input int a, input longint v);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 3'(a);
      bus.coef_data = 16'(v);
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      h_m[a] = v;
   endtask

   task automatic do_flush();
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd12345;
      #2 chk("flush_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_no_accept", bus.out_valid, 0);
      for (int k = 0; k < TPP; k++) x_m[k] = 0;
      sat_m = 0;
      chk("flush_sat", bus.sat_flag, 0);
   endtask

   // One sample, four phases with out_ready held high; expectations from exp[]
   // or, when use_model is set, from the reference model.
   task automatic burst(input string tag, input longint s, input longint exp_in, input bit use_model);
      longint exp[L];
      bit     sx;
      model_push(s);
      for (int p = 0; p < L; p++) begin
         exp[p] = model_out(p, sx);
         if (sx) sat_m = 1;
         if (!use_model) exp[p] = exp_in;
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'(s);
      bus.out_ready = 1'b1;
      #2 chk($sformatf("%s_in_ready", tag), bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int p = 0; p < L; p++) begin
         chk($sformatf("%s_valid_ph%0d", tag, p), bus.out_valid, 1);
         chk($sformatf("%s_phase_ph%0d", tag, p), bus.out_phase, p);
         chk($sformatf("%s_data_ph%0d", tag, p), bus.out_data, exp[p]);
         @(posedge clk); #1;
      end
      chk($sformatf("%s_idle", tag), bus.out_valid, 0);
   endtask

   // Random valid/ready traffic; outputs scored against a queue filled at accept time.
   task automatic stream(input string tag, input int n);
      longint q[$];
      int     ph_q[$];
      int     sent, cyc;
      longint d, e;
      bit     sx;
      sent = 0;
      cyc  = 0;
      while ((sent < n || q.size() > 0) && cyc < 2000) begin
         d = rnd16();
         bus.in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
         bus.in_data   = 16'(d);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #2;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk({tag, "_extra_out"}, 1, 0);
            else begin
               chk({tag, "_data"}, bus.out_data, q.pop_front());
               chk({tag, "_phase"}, bus.out_phase, ph_q.pop_front());
            end
            if (bus.out_phase == 2'(L - 1) && bus.in_valid)
               chk({tag, "_no_bubble"}, bus.in_ready, 1);
         end
         if (bus.in_valid && bus.in_ready) begin
            model_push(d);
            for (int p = 0; p < L; p++) begin
               e = model_out(p, sx);
               if (sx) sat_m = 1;
               q.push_back(e);
               ph_q.push_back(p);
            end
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk({tag, "_budget"}, (cyc < 2000) ? 1 : 0, 1);
      chk({tag, "_drained"}, q.size(), 0);
      @(posedge clk); #1;
      chk({tag, "_sat"}, bus.sat_flag, sat_m);
   endtask

   initial begin
      longint ex[L];
      bit     sx;

      //        fl ld  coef    smp     e       sat
      tab[0] = '{0, 1, 16384,  1000,   500,    0};
      tab[1] = '{0, 0, 0,      0,      500,    0};
      tab[2] = '{0, 0, 0,      0,      0,      0};
      tab[3] = '{0, 1, 32767,  32767,  32766,  0};
      tab[4] = '{0, 0, 0,      32767,  32767,  1};
      tab[5] = '{1, 0, 0,      0,      0,      0};
      tab[6] = '{0, 0, 0,      -32768, -32767, 0};
      tab[7] = '{0, 0, 0,      -32768, -32768, 1};
      tab[8] = '{1, 1, 1,      16384,  1,      0};
      tab[9] = '{1, 0, 0,      16383,  0,      0};

      for (int i = 0; i < NT; i++) h_m[i] = 0;
      for (int k = 0; k < TPP; k++) x_m[k] = 0;
      sat_m = 0;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.flush     = 1'b0;
      #12 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_phase", bus.out_phase, 0);
      chk("rst_sat", bus.sat_flag, 0);

      // Directed table: impulse, saturation both ways, flush, rounding.
      for (int i = 0; i < 10; i++) begin
         if (tab[i].fl) do_flush();
         if (tab[i].ld) for (int a = 0; a < NT; a++) write_coef(a, tab[i].coef);
         burst($sformatf("tab%0d", i), tab[i].smp, tab[i].e, 1'b0);
         chk($sformatf("tab%0d_sat", i), bus.sat_flag, tab[i].sat);
      end

      // Backpressure at phase 2, ignored mid-burst coefficient write, back-to-back input.
      do_flush();
      for (int a = 0; a < NT; a++) write_coef(a, 1000 * (a + 1));
      bus.in_valid = 1'b1; bus.in_data = 16'sd3000; bus.out_ready = 1'b1;
      model_push(3000);
      for (int p = 0; p < L; p++) ex[p] = model_out(p, sx);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp_ph0", bus.out_data, ex[0]);
      bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 16'sd0;
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      chk("bp_ph1", bus.out_data, ex[1]);
      @(posedge clk); #1;
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = -16'sd2000;
      for (int c = 0; c < 5; c++) begin
         #2 chk("bp_hold_in_ready", bus.in_ready, 0);
         @(posedge clk); #1;
         chk("bp_hold_valid", bus.out_valid, 1);
         chk("bp_hold_phase", bus.out_phase, 2);
         chk("bp_hold_data", bus.out_data, ex[2]);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ph3_phase", bus.out_phase, 3);
      chk("bp_ph3_data", bus.out_data, ex[3]);
      #2 chk("bp_b2b_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      model_push(-2000);
      for (int p = 0; p < L; p++) ex[p] = model_out(p, sx);
      for (int p = 0; p < L; p++) begin
         chk("b2b_valid", bus.out_valid, 1);
         chk("b2b_phase", bus.out_phase, p);
         chk("b2b_data", bus.out_data, ex[p]);
         @(posedge clk); #1;
      end
      chk("b2b_idle", bus.out_valid, 0);
      write_coef(0, 0);
      burst("idle_coef", 700, 0, 1'b1);

      // Randomized traffic against the model.
      do_flush();
      for (int a = 0; a < NT; a++) write_coef(a, rnd16());
      stream("rnd_full", 40);
      do_flush();
      for (int a = 0; a < NT; a++) write_coef(a, rnd16() >>> 4);
      stream("rnd_small", 40);

      // Asynchronous reset at phase 1 abandons the burst and clears coefficients.
      bus.in_valid = 1'b1; bus.in_data = 16'sd4000; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_phase_before", bus.out_phase, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_out_valid", bus.out_valid, 0);
      chk("rstmid_out_data", bus.out_data, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_in_ready", bus.in_ready, 1);
      chk("rstmid_sat", bus.sat_flag, 0);
      for (int i = 0; i < NT; i++) h_m[i] = 0;
      for (int k = 0; k < TPP; k++) x_m[k] = 0;
      sat_m = 0;
      burst("post_rst", 5000, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
